// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: pipeline control, the
// decode instruction's operand/destination fields, and the resulting
// forwarding selects, stall request and statistics.
interface hazard_scoreboard_if #(
  parameter int REGW = 5,
  parameter int SELW = 2
);
  logic            advance;
  logic            flush;
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic            id_wen;
  logic [REGW-1:0] id_wsel;
  logic            id_is_load;
  logic [SELW-1:0] fwd_rs_sel;
  logic [SELW-1:0] fwd_rt_sel;
  logic            stall;
  logic [SELW-1:0] occupancy;
  logic [15:0]     perf_stalls;

  // pipeline control / decode side
  modport master (
    output advance, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wen, id_wsel, id_is_load,
    input  fwd_rs_sel, fwd_rt_sel, stall, occupancy, perf_stalls
  );

  // scoreboard side
  modport slave (
    input  advance, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wen, id_wsel, id_is_load,
    output fwd_rs_sel, fwd_rt_sel, stall, occupancy, perf_stalls
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard / forwarding scoreboard. Keeps a shift structure of the
// destination registers of all in-flight instructions (stage 1 = EX) and
// derives, for the instruction in decode, which stage each source should
// forward from and whether a load-use hazard forces a stall.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int REGW       = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(STAGES + 1)
) (
  input logic                CLK,
  input logic                RST,
  hazard_scoreboard_if.slave bus
);

  // tracked entries, index 1 is the youngest (EX)
  logic [STAGES:1]           valid_reg;
  logic [STAGES:1]           load_reg;
  logic [STAGES:1][REGW-1:0] wsel_reg;
  logic [STAGES:1]           valid_next;
  logic [STAGES:1]           load_next;
  logic [STAGES:1][REGW-1:0] wsel_next;
  logic [15:0]               perf_reg;

  logic            ins;
  logic            stall;
  logic            rs_haz;
  logic            rt_haz;
  logic [SELW-1:0] rs_k;
  logic [SELW-1:0] rt_k;
  logic [SELW-1:0] occ;

  // Youngest-writer search: scan oldest to youngest so the lowest matching
  // stage is the last one written and therefore wins.
  always_comb begin
    rs_k   = '0;
    rt_k   = '0;
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (bus.id_rs_used && (bus.id_rs != '0) && valid_reg[k] &&
          (wsel_reg[k] == bus.id_rs)) begin
        rs_k   = SELW'(k);
        rs_haz = load_reg[k] && (k < LOAD_STAGE);
      end
      if (bus.id_rt_used && (bus.id_rt != '0) && valid_reg[k] &&
          (wsel_reg[k] == bus.id_rt)) begin
        rt_k   = SELW'(k);
        rt_haz = load_reg[k] && (k < LOAD_STAGE);
      end
    end
  end

  // A flush squashes the decode instruction, so it can never also stall.
  assign stall = bus.id_valid & (rs_haz | rt_haz) & ~bus.flush;
  assign ins   = bus.id_valid & bus.id_wen & (bus.id_wsel != '0) &
                 ~bus.flush & ~stall;

  // Load data not yet available: read the register file (sel 0) while stalled.
  assign bus.fwd_rs_sel = rs_haz ? '0 : rs_k;
  assign bus.fwd_rt_sel = rt_haz ? '0 : rt_k;
  assign bus.stall      = stall;

  // Next-state of the shift structure: decode feeds stage 1, the rest shift.
  genvar gi;
  for (gi = 1; gi <= STAGES; gi++) begin : g_entry
    if (gi == 1) begin : g_head
      assign valid_next[gi] = ins;
      assign load_next[gi]  = bus.id_is_load;
      assign wsel_next[gi]  = bus.id_wsel;
    end else begin : g_tail
      assign valid_next[gi] = valid_reg[gi-1];
      assign load_next[gi]  = load_reg[gi-1];
      assign wsel_next[gi]  = wsel_reg[gi-1];
    end
  end

  // Population count of valid entries.
  always_comb begin
    occ = '0;
    for (int k = 1; k <= STAGES; k++) begin
      occ = occ + SELW'(valid_reg[k]);
    end
  end

  assign bus.occupancy   = occ;
  assign bus.perf_stalls = perf_reg;

  // Entry register: shifts only when the pipeline advances.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_reg <= '0;
      load_reg  <= '0;
      wsel_reg  <= '0;
    end else if (bus.advance) begin
      valid_reg <= valid_next;
      load_reg  <= load_next;
      wsel_reg  <= wsel_next;
    end
  end

  // Saturating count of stall cycles that actually cost an advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_reg <= '0;
    end else if (bus.advance && stall && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table on the default
// configuration, a mid-operation reset on a 4-stage build and a counter
// saturation run on an 8-stage build.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst3, rst4, rst8;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REGW(5), .SELW(2)) b3 ();
  hazard_scoreboard_if #(.REGW(5), .SELW(3)) b4 ();
  hazard_scoreboard_if #(.REGW(5), .SELW(4)) b8 ();

  hazard_scoreboard #(.STAGES(3), .REGW(5), .LOAD_STAGE(2), .SELW(2)) u3 (
    .CLK(clk), .RST(rst3), .bus(b3));
  hazard_scoreboard #(.STAGES(4), .REGW(5), .LOAD_STAGE(2), .SELW(3)) u4 (
    .CLK(clk), .RST(rst4), .bus(b4));
  hazard_scoreboard #(.STAGES(8), .REGW(5), .LOAD_STAGE(8), .SELW(4)) u8 (
    .CLK(clk), .RST(rst8), .bus(b8));

  typedef struct {
    logic       adv, fl, val;
    logic [4:0] rs, rt;
    logic       rsu, rtu, wen;
    logic [4:0] wsel;
    logic       ld;
    int         e_rs, e_rt, e_stall, e_occ, e_perf;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t mk(input logic adv, input logic fl, input logic val,
                              input int rs, input int rt,
                              input logic rsu, input logic rtu, input logic wen,
                              input int wsel, input logic ld,
                              input int e_rs, input int e_rt, input int e_stall,
                              input int e_occ, input int e_perf);
    vec_t v;
    v.adv = adv; v.fl = fl; v.val = val;
    v.rs = 5'(rs); v.rt = 5'(rt);
    v.rsu = rsu; v.rtu = rtu; v.wen = wen;
    v.wsel = 5'(wsel); v.ld = ld;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall;
    v.e_occ = e_occ; v.e_perf = e_perf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    // idle all buses, hold every instance in reset
    rst3 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    b3.advance = 0; b3.flush = 0; b3.id_valid = 0; b3.id_rs = 0; b3.id_rt = 0;
    b3.id_rs_used = 0; b3.id_rt_used = 0; b3.id_wen = 0; b3.id_wsel = 0; b3.id_is_load = 0;
    b4.advance = 0; b4.flush = 0; b4.id_valid = 0; b4.id_rs = 0; b4.id_rt = 0;
    b4.id_rs_used = 0; b4.id_rt_used = 0; b4.id_wen = 0; b4.id_wsel = 0; b4.id_is_load = 0;
    b8.advance = 0; b8.flush = 0; b8.id_valid = 0; b8.id_rs = 0; b8.id_rt = 0;
    b8.id_rs_used = 0; b8.id_rt_used = 0; b8.id_wen = 0; b8.id_wsel = 0; b8.id_is_load = 0;

    //            adv fl val rs  rt rsu rtu wen wsel ld | rs rt st occ perf
    vt[0]  = mk(0, 0, 0,  0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 1,  1,  2, 1, 1, 1,  8, 0,  0, 0, 0, 0, 0);
    vt[2]  = mk(1, 0, 1,  8,  0, 1, 0, 0,  0, 0,  1, 0, 0, 1, 0);
    vt[3]  = mk(1, 0, 1,  8,  0, 1, 0, 0,  0, 0,  2, 0, 0, 1, 0);
    vt[4]  = mk(1, 0, 1,  8,  0, 1, 0, 0,  0, 0,  3, 0, 0, 1, 0);
    vt[5]  = mk(1, 0, 1,  8,  0, 1, 0, 1,  9, 1,  0, 0, 0, 0, 0);
    vt[6]  = mk(1, 0, 1,  0,  9, 0, 1, 1, 10, 0,  0, 0, 1, 1, 0);
    vt[7]  = mk(1, 0, 1,  0,  9, 0, 1, 1, 10, 0,  0, 2, 0, 1, 1);
    vt[8]  = mk(1, 0, 1, 10,  9, 1, 1, 1,  4, 0,  1, 3, 0, 2, 1);
    vt[9]  = mk(1, 0, 1, 10,  0, 1, 0, 1,  4, 0,  2, 0, 0, 2, 1);
    vt[10] = mk(1, 0, 1,  4, 10, 1, 1, 1,  0, 0,  1, 3, 0, 3, 1);
    vt[11] = mk(1, 0, 1,  0,  4, 1, 1, 0,  0, 0,  0, 2, 0, 2, 1);
    vt[12] = mk(1, 0, 1,  4,  0, 1, 0, 1, 12, 1,  3, 0, 0, 1, 1);
    vt[13] = mk(1, 1, 1, 12,  0, 1, 0, 1, 13, 0,  0, 0, 0, 1, 1);
    vt[14] = mk(1, 0, 1, 12,  0, 1, 0, 0,  0, 0,  2, 0, 0, 1, 1);
    vt[15] = mk(1, 0, 1,  0,  0, 0, 0, 1, 15, 1,  0, 0, 0, 1, 1);
    for (int i = 16; i <= 20; i++)
      vt[i] = mk(0, 0, 1, 0, 15, 0, 1, 0, 0, 0,  0, 0, 1, 1, 1);
    vt[21] = mk(1, 0, 1,  0, 15, 0, 1, 0,  0, 0,  0, 0, 1, 1, 1);
    vt[22] = mk(0, 0, 1,  0, 15, 0, 1, 0,  0, 0,  0, 2, 0, 1, 2);
    vt[23] = mk(1, 0, 1,  0, 15, 0, 1, 1, 20, 1,  0, 2, 0, 1, 2);
    vt[24] = mk(0, 0, 0, 20,  0, 1, 0, 0,  0, 0,  0, 0, 0, 2, 2);
    vt[25] = mk(0, 0, 1, 20,  0, 1, 0, 0,  0, 0,  0, 0, 1, 2, 2);

    @(posedge clk);
    #1;
    rst3 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;

    // ---------------- default configuration, table driven ----------------
    for (int i = 0; i < 26; i++) begin
      b3.advance = vt[i].adv; b3.flush = vt[i].fl; b3.id_valid = vt[i].val;
      b3.id_rs = vt[i].rs; b3.id_rt = vt[i].rt;
      b3.id_rs_used = vt[i].rsu; b3.id_rt_used = vt[i].rtu;
      b3.id_wen = vt[i].wen; b3.id_wsel = vt[i].wsel; b3.id_is_load = vt[i].ld;
      #2;
      chk($sformatf("v%0d rs_sel", i), 32'(b3.fwd_rs_sel), vt[i].e_rs);
      chk($sformatf("v%0d rt_sel", i), 32'(b3.fwd_rt_sel), vt[i].e_rt);
      chk($sformatf("v%0d stall", i), 32'(b3.stall), vt[i].e_stall);
      chk($sformatf("v%0d occupancy", i), 32'(b3.occupancy), vt[i].e_occ);
      chk($sformatf("v%0d perf", i), 32'(b3.perf_stalls), vt[i].e_perf);
      $display("vec %0d: rs_sel=%0d rt_sel=%0d stall=%0d occ=%0d perf=%0d", i,
               b3.fwd_rs_sel, b3.fwd_rt_sel, b3.stall, b3.occupancy, b3.perf_stalls);
      @(posedge clk);
      #1;
    end
    b3.advance = 0;

    // ---------------- 4 stages: mid-operation reset ----------------
    b4.id_valid = 1; b4.id_wen = 1; b4.id_wsel = 7; b4.id_is_load = 1; b4.advance = 1;
    @(posedge clk); #1;
    b4.id_wsel = 1; b4.id_is_load = 0; b4.id_rt = 7; b4.id_rt_used = 1;
    #1;
    chk("s4 load-use stall", 32'(b4.stall), 1);
    chk("s4 load-use rt_sel", 32'(b4.fwd_rt_sel), 0);
    @(posedge clk); #1;
    b4.id_rt_used = 0;
    for (int w = 1; w <= 4; w++) begin
      b4.id_wsel = 5'(w);
      @(posedge clk); #1;
    end
    b4.advance = 0; b4.id_wen = 0;
    b4.id_rs = 1; b4.id_rs_used = 1; b4.id_rt = 4; b4.id_rt_used = 1;
    #1;
    chk("s4 full occupancy", 32'(b4.occupancy), 4);
    chk("s4 oldest rs_sel", 32'(b4.fwd_rs_sel), 4);
    chk("s4 youngest rt_sel", 32'(b4.fwd_rt_sel), 1);
    chk("s4 perf before reset", 32'(b4.perf_stalls), 1);
    $display("s4 full: occ=%0d rs_sel=%0d rt_sel=%0d perf=%0d",
             b4.occupancy, b4.fwd_rs_sel, b4.fwd_rt_sel, b4.perf_stalls);
    #1;
    rst4 = 1'b1;
    #1;
    chk("s4 reset occupancy", 32'(b4.occupancy), 0);
    chk("s4 reset rs_sel", 32'(b4.fwd_rs_sel), 0);
    chk("s4 reset rt_sel", 32'(b4.fwd_rt_sel), 0);
    chk("s4 reset perf", 32'(b4.perf_stalls), 0);
    $display("s4 reset: occ=%0d rs_sel=%0d rt_sel=%0d perf=%0d",
             b4.occupancy, b4.fwd_rs_sel, b4.fwd_rt_sel, b4.perf_stalls);
    #1;
    rst4 = 1'b0;
    b4.id_wen = 1; b4.id_wsel = 5; b4.id_rs = 5; b4.id_rt_used = 0; b4.advance = 1;
    @(posedge clk); #1;
    b4.advance = 0; b4.id_wen = 0;
    #1;
    chk("s4 post-reset rs_sel", 32'(b4.fwd_rs_sel), 1);
    chk("s4 post-reset occupancy", 32'(b4.occupancy), 1);
    $display("s4 post-reset insert: rs_sel=%0d occ=%0d", b4.fwd_rs_sel, b4.occupancy);

    // ---------------- 8 stages: perf counter saturation ----------------
    // A load to r9 that also reads r9 stalls 7 of every 8 advancing edges.
    b8.id_valid = 1; b8.id_wen = 1; b8.id_wsel = 9; b8.id_is_load = 1;
    b8.id_rt = 9; b8.id_rt_used = 1; b8.advance = 1;
    repeat (74880) @(posedge clk);
    #1;
    chk("s8 perf pre-saturation", 32'(b8.perf_stalls), 32'hFFF0);
    $display("s8 after 74880 edges: perf=%0h", b8.perf_stalls);
    repeat (120) @(posedge clk);
    #1;
    chk("s8 perf saturated", 32'(b8.perf_stalls), 32'hFFFF);
    $display("s8 after 75000 edges: perf=%0h", b8.perf_stalls);
    b8.advance = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding scoreboard for the pipelined MIPS datapath. It tracks the destination register of every in-flight instruction from decode through writeback. It produces per-source forwarding selects and a load-use stall for the instruction currently in decode. It replaces the fixed EX/MEM compare logic with a depth-generic shift structure that supports flush, pipeline freeze and stall-cycle accounting.

## Interface
Parameters:
- STAGES, 3, number of tracked post-decode stages (stage 1 = EX, 2 = MEM, 3 = WB); legal 2..8
- REGW, 5, register index width
- LOAD_STAGE, 2, stage index at whose output load data becomes forwardable; legal 1..STAGES
- SELW, $clog2(STAGES+1), width of forwarding selects

Ports (clock and reset first):
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- advance  in  1  pipeline moves this cycle (ihit-qualified, low while dhit pending)
- flush  in  1  squash the instruction leaving decode; a bubble enters stage 1
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  REGW  source register indices in decode
- id_rs_used, id_rt_used  in  1  the source is actually read
- id_wen  in  1  decode instruction writes a register
- id_wsel  in  REGW  decode destination register
- id_is_load  in  1  decode instruction is a load
- fwd_rs_sel, fwd_rt_sel  out  SELW  0 = register file, k = forward from stage k
- stall  out  1  load-use hazard; hold IF/ID, inject bubble
- occupancy  out  SELW  count of valid tracked entries
- perf_stalls  out  16  saturating count of cycles with stall & advance

## Operation
- State: entries 1..STAGES, each {valid, wsel, is_load}.
- Insertion qualifier ins = id_valid & id_wen & (id_wsel != 0) & ~flush & ~stall.
- On a clock edge with advance=1:
  - entry[k] <= entry[k-1] for k = 2..STAGES; the old entry[STAGES] retires.
  - entry[1] <= {ins, id_wsel, id_is_load}.
  - A stall or flush writes a bubble (valid=0) into entry[1].
- advance=0: all entries hold; perf_stalls holds.
- Source match for source s (rs or rt): s_used & (s != 0) & entry[k].valid & entry[k].wsel == s.
- Priority: the lowest matching k (youngest writer) wins. Older matches are ignored.
- Forward select:
  - If the winning entry has is_load=1 and k < LOAD_STAGE: sel = 0, and that source raises stall.
  - Otherwise sel = k.
  - No match: sel = 0.
- stall = rs hazard | rt hazard, gated by id_valid. stall is not asserted while flush=1, because flush dominates.
- Register 0 never matches, never inserts, never stalls.
- occupancy = popcount of entry valids.
- perf_stalls increments on edges where stall & advance, and saturates at 16'hFFFF.

## Timing
- Reset (RST high, asynchronous): all entries invalid, perf_stalls = 0. Therefore fwd_*_sel = 0, stall = 0, occupancy = 0.
- RST has immediate effect mid-operation; the first edge after release behaves like a normal edge.
- fwd_*_sel and stall are combinational from registered entries plus the id_* inputs. They are valid in the same cycle the decode inputs are valid.
- Entry state updates only at the rising CLK edge with advance=1. Latency from insertion to appearing at stage k is k advancing edges.
- Simultaneous stall and flush: flush wins. The bubble is inserted, stall=0, and no perf_stalls increment.
- Stall over multiple cycles: a bubble is inserted each advancing edge until the load reaches LOAD_STAGE. With default parameters, a load-use sequence stalls exactly 1 advancing cycle.
- Same register written by consecutive instructions: the youngest entry forwards.

## Test plan
- Reset, then back-to-back ALU ops: insert wsel=8 with advance. Next decode reads rs=8 -> fwd_rs_sel=1. One advance later -> 2. Then 3. Then 0 after retirement.
- Load-use: insert load wsel=9, next decode reads rt=9 -> stall=1, fwd_rt_sel=0. After one advance (bubble inserted) -> stall=0, fwd_rt_sel=2. perf_stalls=1.
- Youngest wins: stage1 wsel=4 and stage2 wsel=4 valid, decode rs=4 -> fwd_rs_sel=1. Register 0: decode rs=0 with stage1 wsel=0 attempt -> no entry inserted, sel=0, occupancy unchanged.
- Freeze: advance=0 for 5 cycles with a stall condition present -> entries, occupancy and perf_stalls unchanged, stall stays 1.
- Flush during hazard: load in stage1 with matching decode and flush=1 -> stall=0. After the edge, entry[1] is invalid and the load is in stage 2.
- Mid-operation reset: STAGES=4, all entries valid, RST pulsed between edges -> occupancy=0 and all selects 0 immediately. perf_stalls=0. Saturation check: force 65536 stall cycles -> perf_stalls=16'hFFFF.
